// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS MEM stage: FSM state encoding,
// default bus widths and the word-alignment pattern.
package mips_mem_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam logic [1:0] ALIGN_MASK_OK = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_watchdog.sv
// Ack watchdog for the MEM stage: counts REQ cycles without ack and flags
// expiry on the cycle the count would reach TIMEOUT_CYCLES.
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    import mips_mem_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_r;

    // Wait counter: held at zero outside REQ, advances per unacknowledged cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (count_en) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign expired = count_en && (count_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: word load/store over a req/ack memory port with upstream stall.
// Optional ack watchdog and timeout_err port enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int DATA_W         = mips_mem_pkg::DATA_W,
    parameter int REG_AW         = mips_mem_pkg::REG_AW,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_AW-1:0] r_target_in,
    input  logic              Reg_Write_in,
    input  logic              M2R_in,
    input  logic              Mem_Read,
    input  logic              Mem_Write,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] address_out,
    output logic [DATA_W-1:0] data_out,
    output logic [REG_AW-1:0] r_target_out,
    output logic              Reg_Write_out,
    output logic              M2R_out,
    output logic              valid_out,
    output logic              stall_out,
    output logic              misalign_err
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);
    import mips_mem_pkg::*;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_e        state_r, state_nxt_s;
    logic [DATA_W-1:0] addr_r, wdata_r, rdata_r;
    logic [REG_AW-1:0] rt_r;
    logic              rw_r, m2r_r, we_r, to_r;
    logic              is_mem_s, aligned_s, capture_s, ack_load_s, set_to_s, expired_s;

    assign is_mem_s  = Mem_Read | Mem_Write;
    assign aligned_s = (alu_result[1:0] == ALIGN_MASK_OK);

`ifdef MEM_TIMEOUT_EN
    mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_r != ST_REQ),
        .count_en ((state_r == ST_REQ) && !mem_ack),
        .expired  (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    // State register and hold registers for the in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            rt_r    <= '0;
            rw_r    <= 1'b0;
            m2r_r   <= 1'b0;
            we_r    <= 1'b0;
            to_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                addr_r  <= alu_result;
                wdata_r <= store_data;
                rt_r    <= r_target_in;
                rw_r    <= Reg_Write_in;
                m2r_r   <= M2R_in;
                we_r    <= Mem_Write;
                rdata_r <= '0;
                to_r    <= 1'b0;
            end else if (ack_load_s) begin
                rdata_r <= mem_rdata;
            end else if (set_to_s) begin
                to_r <= 1'b1;
            end
        end
    end

    // Next-state and output decode; reset forces every output to zero
    always_comb begin
        state_nxt_s   = state_r;
        capture_s     = 1'b0;
        ack_load_s    = 1'b0;
        set_to_s      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        address_out   = '0;
        data_out      = '0;
        r_target_out  = '0;
        Reg_Write_out = 1'b0;
        M2R_out       = 1'b0;
        valid_out     = 1'b0;
        stall_out     = 1'b0;
        misalign_err  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        timeout_err   = 1'b0;
`endif
        if (rst) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (!is_mem_s) begin
                            address_out   = alu_result;
                            r_target_out  = r_target_in;
                            Reg_Write_out = Reg_Write_in;
                            M2R_out       = M2R_in;
                            valid_out     = 1'b1;
                        end else if (aligned_s) begin
                            capture_s   = 1'b1;
                            stall_out   = 1'b1;
                            state_nxt_s = ST_REQ;
                        end else begin
                            misalign_err = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    mem_req   = 1'b1;
                    mem_we    = we_r;
                    mem_addr  = addr_r;
                    mem_wdata = wdata_r;
                    stall_out = 1'b1;
                    if (mem_ack) begin
                        ack_load_s  = ~we_r;
                        state_nxt_s = ST_DONE;
                    end else if (expired_s) begin
                        set_to_s    = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                ST_DONE: begin
                    // rdata_r stays zero for stores and timed-out loads
                    valid_out     = 1'b1;
                    address_out   = addr_r;
                    data_out      = rdata_r;
                    r_target_out  = rt_r;
                    Reg_Write_out = rw_r & ~to_r;
                    M2R_out       = m2r_r;
`ifdef MEM_TIMEOUT_EN
                    timeout_err   = to_r;
`endif
                    state_nxt_s   = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MIPS pipeline MEM stage. Sits between the EX/MEM register and the MEM/WB register, and is the producer for the MEM/WB inputs (address, data, r_target, Reg_Write, M2R).
- Issues word loads/stores to a variable-latency data memory over a req/ack handshake.
- Asserts stall_out to freeze IF..EX/MEM while an access is outstanding, and emits bubbles to MEM/WB until the access completes.

Parameters:
DATA_W, 32, word/address width
REG_AW, 5, register-index width
TIMEOUT_CYCLES, 64, ack watchdog limit; used only when MEM_TIMEOUT_EN is defined

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_in  in  1  EX/MEM holds a live instruction
alu_result  in  DATA_W  effective address / ALU value
store_data  in  DATA_W  rt value for stores
r_target_in  in  REG_AW  destination register
Reg_Write_in  in  1  writeback enable
M2R_in  in  1  select memory data at WB
Mem_Read  in  1  load
Mem_Write  in  1  store
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  DATA_W  word address (byte address, [1:0]=0)
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data, valid with mem_ack
mem_ack  in  1  access complete
address_out  out  DATA_W  to MEM/WB address_in
data_out  out  DATA_W  to MEM/WB data_in
r_target_out  out  REG_AW  to MEM/WB r_target_in
Reg_Write_out  out  1  to MEM/WB Reg_Write_in, gated by valid_out
M2R_out  out  1  to MEM/WB M2R_in
valid_out  out  1  outputs carry a real instruction
stall_out  out  1  freeze upstream stages and EX/MEM
misalign_err  out  1  one-cycle pulse on misaligned access

Behaviour:
- One clock, clk. Reset rst is synchronous, active-high.
- Reset: on any edge with rst=1 the state goes to IDLE and all held registers clear to 0. While rst=1, every output is forced to 0 (mem_req, stall_out, valid_out, Reg_Write_out, misalign_err, all buses).
- States: IDLE, REQ, DONE.
- IDLE, valid_in=0: bubble; all outputs 0.
- IDLE, valid_in=1, no memory op: combinational pass-through, zero added latency.
  - address_out=alu_result, data_out=0, the other fields pass through.
  - valid_out=1, stall_out=0.
- IDLE, valid_in=1, memory op, alu_result[1:0]==0:
  - Capture alu_result, store_data, r_target, Reg_Write, M2R and we=Mem_Write into hold registers.
  - stall_out=1 combinationally, valid_out=0; next state REQ.
- IDLE, valid_in=1, memory op, alu_result[1:0]!=0:
  - No access; misalign_err=1 for this cycle.
  - Bubble out (valid_out=0, Reg_Write_out=0), stall_out=0.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_wdata driven from hold registers and stable until ack.
  - stall_out=1, valid_out=0.
  - On mem_ack: if load, capture mem_rdata into the data register; next state DONE. Otherwise stay in REQ.
  - mem_ack outside REQ is ignored.
- DONE:
  - mem_req=0, stall_out=0, valid_out=1.
  - Outputs come from hold registers; data_out = load data, or 0 for a store.
  - Upstream advances at this edge; next state IDLE. valid_in is not examined in DONE.
- Latency: a memory op with ack on the first REQ cycle takes 3 cycles, IDLE to DONE. Each extra ack-wait cycle adds 1.
- Mem_Read and Mem_Write both set: treated as a store.
- Reg_Write_out = held Reg_Write & valid_out, so a MEM/WB register with no enable captures harmless bubbles during a stall.
- Reset during REQ: mem_req drops at the reset edge. A late ack after reset is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES: go to DONE with data 0 and Reg_Write_out forced 0, and pulse output port timeout_err for 1 cycle.
- Undefined: no counter and no timeout_err port; REQ waits indefinitely.

Decomposition:
- Package mips_mem_pkg holds: the state enum (IDLE/REQ/DONE), DATA_W, REG_AW, and the alignment-mask constant 2'b00.
- Sub-module mem_watchdog (counter plus compare) is instantiated only under MEM_TIMEOUT_EN. The FSM stays in the top module.

Test Plan:
- Non-memory op: valid_in=1, alu_result=0x10, Reg_Write_in=1, r_target_in=5 -> same cycle valid_out=1, address_out=0x10, Reg_Write_out=1, stall_out=0.
- Load at 0x100, ack after 2 REQ cycles with rdata=0xDEADBEEF:
  - stall_out=1 for 3 cycles.
  - DONE cycle: data_out=0xDEADBEEF, M2R_out=1, valid_out=1.
  - mem_req low afterwards.
- Store at 0x200 of 0x12345678, immediate ack -> one mem_req cycle with mem_we=1, mem_addr=0x200, mem_wdata=0x12345678; DONE shows Reg_Write_out=0.
- Misaligned load at 0x102 -> misalign_err pulses 1 cycle, mem_req never asserts, valid_out=0, stall_out=0.
- rst asserted during REQ, then ack one cycle later -> state IDLE, mem_req=0 after the edge, the ack produces no valid_out.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack -> after 4 REQ cycles timeout_err pulses, DONE with Reg_Write_out=0, data_out=0.
